mem_arbiter: RTL and testbench

- Shares the single main-memory block port between the instruction cache and the data cache.
- Each cache presents a block read (and, for the data cache, a block write) using the same READ/ADDRESS/BUSYWAIT handshake that the caches already use toward memory.
- The arbiter serialises the requests, grants by round-robin on ties, drives the memory port from registers, and returns data and busywait to the owning cache.
- It sits between both cache controllers and the memory model in the processor top level.

---
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction cache and the data cache share one
// main-memory block port. Requests use the caches' READ/ADDRESS/BUSYWAIT
// handshake. Simultaneous requests are granted round-robin, and one transfer
// runs at a time. The memory port is driven from registers. Each block read
// lands in the owner's READDATA register, and the owner's BUSYWAIT drops for
// exactly one cycle when its transfer completes.

module mem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 128,
    parameter int MAX_WAIT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              TIMEOUT_ERR
);

    localparam int               CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

    state_t           state;
    state_t           next_state;
    owner_t           owner;
    logic             last_grant_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_write;

    logic             i_pend;
    logic             d_pend;
    logic             grant_i;
    logic             grant_d;
    logic             mem_done;
    logic             mem_timeout;

    // Decode pending requests, pick a winner in IDLE and detect the end of a memory transaction
    always_comb begin
        i_pend      = I_READ;
        d_pend      = D_READ | D_WRITE;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        mem_done    = 1'b0;
        mem_timeout = 1'b0;
        if (state == ST_IDLE) begin
            grant_i = i_pend & (~d_pend | last_grant_d);
            grant_d = d_pend & ~grant_i;
        end
        if (state == ST_WAIT) begin
            mem_done    = ~MEM_BUSYWAIT;
            mem_timeout = MEM_BUSYWAIT & (wait_cnt == CNT_LAST);
        end
    end

    // State register; reset abandons any transfer in progress
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT (until done or timeout) -> RESP -> IDLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (grant_i || grant_d) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done || mem_timeout) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Stall each requester unless its own transfer is in the response cycle
    always_comb begin
        I_BUSYWAIT = i_pend & ~((state == ST_RESP) & (owner == OWN_I));
        D_BUSYWAIT = d_pend & ~((state == ST_RESP) & (owner == OWN_D));
    end

    // On a grant, record the owner and round-robin history and latch the request so later input changes are ignored
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            owner         <= OWN_NONE;
            last_grant_d  <= 1'b1;
            is_write      <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else if (grant_i) begin
            owner        <= OWN_I;
            last_grant_d <= 1'b0;
            is_write     <= 1'b0;
            MEM_ADDRESS  <= I_ADDRESS;
        end else if (grant_d) begin
            owner        <= OWN_D;
            last_grant_d <= 1'b1;
            is_write     <= D_WRITE;
            MEM_ADDRESS  <= D_ADDRESS;
            if (D_WRITE) begin
                MEM_WRITEDATA <= D_WRITEDATA;
            end
        end
    end

    // Memory strobes rise with the grant and stay up through ISSUE and WAIT; a write wins when both D strobes are set
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
        end else if (grant_i) begin
            MEM_READ  <= 1'b1;
            MEM_WRITE <= 1'b0;
        end else if (grant_d) begin
            MEM_READ  <= ~D_WRITE;
            MEM_WRITE <= D_WRITE;
        end else if (mem_done || mem_timeout) begin
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
        end
    end

    // Count WAIT cycles so a memory that never releases busywait cannot hang the caches
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Deliver read data (or zero after a timeout) to the owning cache; the other register keeps its value
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            I_READDATA <= '0;
            D_READDATA <= '0;
        end else if (mem_timeout) begin
            if (owner == OWN_I) begin
                I_READDATA <= '0;
            end else if (owner == OWN_D) begin
                D_READDATA <= '0;
            end
        end else if (mem_done && !is_write) begin
            if (owner == OWN_I) begin
                I_READDATA <= MEM_READDATA;
            end else if (owner == OWN_D) begin
                D_READDATA <= MEM_READDATA;
            end
        end
    end

    // Timeout flag is sticky until reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            TIMEOUT_ERR <= 1'b0;
        end else if (mem_timeout) begin
            TIMEOUT_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter against a simple block memory with a
// programmable latency. Each transfer is scored against a transaction-level
// reference. The reference decides the grant order by round-robin, works out
// completion times from the handshake latencies, and tracks the expected
// memory contents and READDATA values.

module tb_mem_arbiter;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 128;
    localparam int MAX_WAIT = 8;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              I_READ;
    logic [ADDR_W-1:0] I_ADDRESS;
    logic [DATA_W-1:0] I_READDATA;
    logic              I_BUSYWAIT;
    logic              D_READ;
    logic              D_WRITE;
    logic [ADDR_W-1:0] D_ADDRESS;
    logic [DATA_W-1:0] D_WRITEDATA;
    logic [DATA_W-1:0] D_READDATA;
    logic              D_BUSYWAIT;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDRESS;
    logic [DATA_W-1:0] MEM_WRITEDATA;
    logic [DATA_W-1:0] MEM_READDATA;
    logic              MEM_BUSYWAIT;
    logic              TIMEOUT_ERR;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .I_READ       (I_READ),
        .I_ADDRESS    (I_ADDRESS),
        .I_READDATA   (I_READDATA),
        .I_BUSYWAIT   (I_BUSYWAIT),
        .D_READ       (D_READ),
        .D_WRITE      (D_WRITE),
        .D_ADDRESS    (D_ADDRESS),
        .D_WRITEDATA  (D_WRITEDATA),
        .D_READDATA   (D_READDATA),
        .D_BUSYWAIT   (D_BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .TIMEOUT_ERR  (TIMEOUT_ERR)
    );

    // Initial contents of every memory block; block 0x15 holds a recognisable marker
    function automatic logic [127:0] pattern(input logic [5:0] a);
        if (a == 6'h15) begin
            return 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001;
        end
        return {4{26'h155_5555, a}};
    endfunction

    // Memory model: busy while the strobe has been high for fewer than mem_lat prior cycles
    logic [127:0] mem_array [64];
    logic         mem_ready = 1'b0;
    int           mem_cnt;
    int           mem_lat   = 1;
    bit           mem_stuck = 1'b0;

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_stuck || (mem_cnt < mem_lat));
    assign MEM_READDATA = mem_array[MEM_ADDRESS];

    // Count how long the current strobe has been held
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_cnt <= 0;
        end else if (MEM_READ || MEM_WRITE) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    // Fill the memory once, then commit writes on their completing cycle
    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int a = 0; a < 64; a++) begin
                mem_array[a] <= pattern(6'(a));
            end
            mem_ready <= 1'b1;
        end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
            mem_array[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
    end

    // Reference model state
    logic [127:0] ref_mem [64];
    bit           model_last_d;
    logic [127:0] model_i_rdata;
    logic [127:0] model_d_rdata;
    bit           model_timeout;

    task automatic modelReset();
        model_last_d  = 1'b1;
        model_i_rdata = '0;
        model_d_rdata = '0;
        model_timeout = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit ir, input logic [5:0] ia, input bit dr, input bit dw,
                                 input logic [5:0] da, input logic [127:0] dd);
        I_READ      = ir;
        I_ADDRESS   = ia;
        D_READ      = dr;
        D_WRITE     = dw;
        D_ADDRESS   = da;
        D_WRITEDATA = dd;
    endtask

    // Run one transfer round: I and/or D request, D optionally raised d_delay cycles later
    task automatic runTransfer(input string tag, input bit i_req, input logic [5:0] i_addr,
                               input bit d_rd, input bit d_wr, input logic [5:0] d_addr,
                               input logic [127:0] d_wdata, input int lat, input int d_delay,
                               input bit stuck);
        bit           d_req;
        bit           i_first;
        bit           serve_i;
        bit           d_raised;
        bit           i_busy;
        bit           d_busy;
        int           lat_eff;
        int           exp_i;
        int           exp_d;
        int           exp_rd;
        int           exp_wr;
        int           e;
        int           i_done;
        int           d_done;
        int           i_low;
        int           d_low;
        int           rd_cyc;
        int           wr_cyc;
        int           spurious;
        logic [127:0] exp_i_data;
        logic [127:0] exp_d_data;
        logic [127:0] got_i;
        logic [127:0] got_d;

        d_req   = d_rd || d_wr;
        lat_eff = stuck ? MAX_WAIT : lat;
        if (i_req && d_req) begin
            i_first = (d_delay > 0) ? 1'b1 : model_last_d;
        end else begin
            i_first = i_req;
        end
        exp_i = -1;
        exp_d = -1;
        if (i_req) exp_i = i_first ? lat_eff + 2 : 2 * lat_eff + 5;
        if (d_req) exp_d = i_first ? 2 * lat_eff + 5 : lat_eff + 2;

        exp_i_data = model_i_rdata;
        exp_d_data = model_d_rdata;
        for (int k = 0; k < 2; k++) begin
            serve_i = ((k == 0) == i_first);
            if (serve_i && i_req) begin
                exp_i_data = stuck ? 128'd0 : ref_mem[i_addr];
            end
            if (!serve_i && d_req) begin
                if (stuck) exp_d_data = '0;
                else if (d_wr) ref_mem[d_addr] = d_wdata;
                else exp_d_data = ref_mem[d_addr];
            end
        end
        exp_rd = (lat_eff + 1) * ((i_req ? 1 : 0) + ((d_req && !d_wr) ? 1 : 0));
        exp_wr = (lat_eff + 1) * (d_wr ? 1 : 0);

        mem_lat   = lat;
        mem_stuck = stuck;
        d_raised  = (d_delay == 0);
        applyStimulus(i_req | I_READ, i_addr, d_raised & d_rd, d_raised & d_wr, d_addr, d_wdata);
        #1;
        if (i_req) checkOutput({tag, ".i_busy_raise"}, 128'(I_BUSYWAIT), 128'd1);
        if (d_req && d_raised) checkOutput({tag, ".d_busy_raise"}, 128'(D_BUSYWAIT), 128'd1);

        e = 0; i_done = -1; d_done = -1; i_low = 0; d_low = 0;
        rd_cyc = 0; wr_cyc = 0; spurious = 0; got_i = '0; got_d = '0;
        while (e < 4 * lat_eff + 20) begin
            @(negedge CLK);
            e++;
            i_busy = I_BUSYWAIT;
            d_busy = D_BUSYWAIT;
            if (MEM_READ && ((i_req && MEM_ADDRESS == i_addr) || (d_req && !d_wr && MEM_ADDRESS == d_addr)))
                rd_cyc++;
            if (MEM_WRITE && MEM_ADDRESS == d_addr && MEM_WRITEDATA == d_wdata)
                wr_cyc++;
            if ((!I_READ && i_busy) || (!(D_READ || D_WRITE) && d_busy))
                spurious++;
            if (I_READ) begin
                if (!i_busy) begin
                    i_low++;
                    if (i_done < 0) begin
                        i_done = e;
                        got_i  = I_READDATA;
                    end
                end else if (i_done >= 0) begin
                    I_READ = 1'b0;
                end
            end
            if (D_READ || D_WRITE) begin
                if (!d_busy) begin
                    d_low++;
                    if (d_done < 0) begin
                        d_done = e;
                        got_d  = D_READDATA;
                    end
                end else if (d_done >= 0) begin
                    D_READ  = 1'b0;
                    D_WRITE = 1'b0;
                end
            end
            if (!d_raised && e == d_delay) begin
                D_READ   = d_rd;
                D_WRITE  = d_wr;
                d_raised = 1'b1;
            end
            if ((!i_req || (i_done >= 0 && !I_READ)) && (!d_req || (d_done >= 0 && !D_READ && !D_WRITE)))
                break;
        end
        I_READ  = 1'b0;
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
        @(negedge CLK);

        if (i_req) begin
            checkOutput({tag, ".i_done_cycle"}, 128'(i_done), 128'(exp_i));
            checkOutput({tag, ".i_low_cycles"}, 128'(i_low), 128'd1);
            checkOutput({tag, ".i_data"}, got_i, exp_i_data);
        end
        if (d_req) begin
            checkOutput({tag, ".d_done_cycle"}, 128'(d_done), 128'(exp_d));
            checkOutput({tag, ".d_low_cycles"}, 128'(d_low), 128'd1);
            if (!d_wr) checkOutput({tag, ".d_data"}, got_d, exp_d_data);
        end
        checkOutput({tag, ".read_strobe_cycles"}, 128'(rd_cyc), 128'(exp_rd));
        checkOutput({tag, ".write_strobe_cycles"}, 128'(wr_cyc), 128'(exp_wr));
        checkOutput({tag, ".spurious_busy"}, 128'(spurious), 128'd0);
        if (stuck) model_timeout = 1'b1;
        checkOutput({tag, ".timeout_err"}, 128'(TIMEOUT_ERR), 128'(model_timeout));
        checkOutput({tag, ".i_readdata_hold"}, I_READDATA, exp_i_data);
        checkOutput({tag, ".d_readdata_hold"}, D_READDATA, exp_d_data);

        model_i_rdata = exp_i_data;
        model_d_rdata = exp_d_data;
        if (i_req && d_req) model_last_d = i_first;
        else if (i_req) model_last_d = 1'b0;
        else if (d_req) model_last_d = 1'b1;
    endtask

    initial begin
        bit           r_i;
        bit           r_dr;
        bit           r_dw;
        int           r_sel;
        int           r_lat;
        int           r_delay;
        logic [5:0]   r_ia;
        logic [5:0]   r_da;
        logic [127:0] r_dd;

        RESET = 1'b0;
        applyStimulus(1'b0, 6'h0, 1'b0, 1'b0, 6'h0, 128'd0);
        for (int a = 0; a < 64; a++) ref_mem[a] = pattern(6'(a));
        modelReset();
        repeat (3) @(negedge CLK);

        checkOutput("reset.mem_read", 128'(MEM_READ), 128'd0);
        checkOutput("reset.mem_write", 128'(MEM_WRITE), 128'd0);
        checkOutput("reset.mem_address", 128'(MEM_ADDRESS), 128'd0);
        checkOutput("reset.mem_writedata", MEM_WRITEDATA, 128'd0);
        checkOutput("reset.i_readdata", I_READDATA, 128'd0);
        checkOutput("reset.d_readdata", D_READDATA, 128'd0);
        checkOutput("reset.timeout_err", 128'(TIMEOUT_ERR), 128'd0);
        RESET = 1'b1;
        @(negedge CLK);

        runTransfer("iread_lat5", 1'b1, 6'h15, 1'b0, 1'b0, 6'h0, 128'd0, 5, 0, 1'b0);

        RESET = 1'b0;
        modelReset();
        @(negedge CLK);
        checkOutput("repulse.i_readdata", I_READDATA, 128'd0);
        RESET = 1'b1;
        @(negedge CLK);
        runTransfer("tie1", 1'b1, 6'h03, 1'b1, 1'b0, 6'h04, 128'd0, 2, 0, 1'b0);
        runTransfer("tie2", 1'b1, 6'h05, 1'b1, 1'b0, 6'h06, 128'd0, 3, 0, 1'b0);

        runTransfer("dwrite", 1'b0, 6'h00, 1'b0, 1'b1, 6'h2A,
                    128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 3, 0, 1'b0);
        runTransfer("dreadback", 1'b0, 6'h00, 1'b1, 1'b0, 6'h2A, 128'd0, 2, 0, 1'b0);
        runTransfer("dwr_in_iwait", 1'b1, 6'h10, 1'b0, 1'b1, 6'h11,
                    128'hFEED_FACE_CAFE_F00D_1111_2222_3333_4444, 4, 2, 1'b0);
        runTransfer("rd_and_wr", 1'b0, 6'h00, 1'b1, 1'b1, 6'h12,
                    128'h5555_AAAA_5555_AAAA_0F0F_F0F0_0F0F_F0F0, 1, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r_i     = 1'($urandom_range(0, 1));
            r_sel   = int'($urandom_range(0, 3));
            r_dr    = (r_sel == 1) || (r_sel == 3);
            r_dw    = (r_sel == 2) || (r_sel == 3);
            if (!r_i && !r_dr && !r_dw) r_i = 1'b1;
            r_lat   = int'($urandom_range(1, 6));
            r_ia    = 6'($urandom_range(0, 7));
            r_da    = 6'($urandom_range(0, 7));
            r_dd    = {$urandom, $urandom, $urandom, $urandom};
            r_delay = 0;
            if (r_i && (r_dr || r_dw) && ($urandom_range(0, 1) == 1))
                r_delay = int'($urandom_range(1, 32'(r_lat + 1)));
            runTransfer($sformatf("rnd%0d", n), r_i, r_ia, r_dr, r_dw, r_da, r_dd, r_lat, r_delay, 1'b0);
        end

        runTransfer("timeout", 1'b1, 6'h07, 1'b0, 1'b0, 6'h0, 128'd0, 1, 0, 1'b1);
        runTransfer("after_timeout", 1'b0, 6'h00, 1'b1, 1'b0, 6'h15, 128'd0, 2, 0, 1'b0);

        mem_lat   = 5;
        mem_stuck = 1'b0;
        applyStimulus(1'b1, 6'h15, 1'b0, 1'b0, 6'h0, 128'd0);
        repeat (3) @(negedge CLK);
        checkOutput("midreset.pre_mem_read", 128'(MEM_READ), 128'd1);
        RESET = 1'b0;
        #1;
        checkOutput("midreset.mem_read", 128'(MEM_READ), 128'd0);
        checkOutput("midreset.mem_address", 128'(MEM_ADDRESS), 128'd0);
        checkOutput("midreset.i_readdata", I_READDATA, 128'd0);
        checkOutput("midreset.timeout_err", 128'(TIMEOUT_ERR), 128'd0);
        checkOutput("midreset.i_busy", 128'(I_BUSYWAIT), 128'd1);
        modelReset();
        @(negedge CLK);
        RESET = 1'b1;
        runTransfer("regrant", 1'b1, 6'h15, 1'b0, 1'b0, 6'h0, 128'd0, 5, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
